// File: rtl/alu_operand_stage_pkg.sv
// Shared types and encodings for the ID/EX operand stage: ALU op codes,
// operand select codes, forward-select codes and the registered EX slot.
package alu_operand_stage_pkg;

  localparam int XLEN = 32;

  // ALU op codes, ADD..AND
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;

  localparam logic [1:0] B_SEL_RS2  = 2'd0;
  localparam logic [1:0] B_SEL_IMM  = 2'd1;
  localparam logic [1:0] B_SEL_FOUR = 2'd2;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [3:0]      alu_op;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
  } ex_slot_t;

  // EX/MEM wins over MEM/WB; x0 is never a forwarding target.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic [4:0] exmem_rd,
    input logic       exmem_we,
    input logic [4:0] memwb_rd,
    input logic       memwb_we
  );
    fwd_sel_e sel;
    sel = FWD_NONE;
    if (rs != 5'd0) begin
      if (exmem_we && (exmem_rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (memwb_we && (memwb_rd == rs)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bundle of decode-slot, forwarding-source, pipeline-control and EX-output
// signals around the operand stage. slave = the stage, master = its environment.
interface alu_operand_stage_if;

  localparam int XLEN = alu_operand_stage_pkg::XLEN;

  logic            stall;
  logic            flush;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [4:0]      id_rd_addr;
  logic [3:0]      id_alu_op;
  logic [1:0]      id_a_sel;
  logic [1:0]      id_b_sel;
  logic            id_reg_write;

  logic [4:0]      exmem_rd;
  logic            exmem_reg_write;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      memwb_rd;
  logic            memwb_reg_write;
  logic [XLEN-1:0] memwb_result;

  logic            ex_valid;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [3:0]      op_code;
  logic [XLEN-1:0] ex_rs2_value;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd_addr;
  logic            ex_reg_write;

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
    input  id_a_sel, id_b_sel, id_reg_write,
    input  exmem_rd, exmem_reg_write, exmem_result,
    input  memwb_rd, memwb_reg_write, memwb_result,
    output ex_valid, in_a, in_b, op_code, ex_rs2_value,
    output ex_pc, ex_rd_addr, ex_reg_write
  );

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
    output id_a_sel, id_b_sel, id_reg_write,
    output exmem_rd, exmem_reg_write, exmem_result,
    output memwb_rd, memwb_reg_write, memwb_result,
    input  ex_valid, in_a, in_b, op_code, ex_rs2_value,
    input  ex_pc, ex_rd_addr, ex_reg_write
  );

endinterface

// File: rtl/alu_operand_stage_forward_mux.sv
// Per-source-register forward mux: picks EX/MEM result, MEM/WB result or the
// registered value; x0 always reads zero.
module alu_operand_stage_forward_mux
  import alu_operand_stage_pkg::*;
(
  input  logic [4:0]      rs_addr_i,
  input  logic [XLEN-1:0] reg_value_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic            exmem_reg_write_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic            memwb_reg_write_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] value_o
);

  fwd_sel_e sel;

  assign sel = fwd_select(rs_addr_i, exmem_rd_i, exmem_reg_write_i,
                          memwb_rd_i, memwb_reg_write_i);

  always_comb begin
    value_o = '0;
    case (sel)
      FWD_EXMEM: value_o = exmem_result_i;
      FWD_MEMWB: value_o = memwb_result_i;
      default:   value_o = (rs_addr_i == 5'd0) ? '0 : reg_value_i;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with operand forwarding and A/B operand selection
// feeding the ALU. Update priority: reset > flush > stall > capture.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  alu_operand_stage_if.slave  bus
);

  ex_slot_t        slot_q, slot_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  alu_operand_stage_forward_mux u_fwd_rs1 (
    .rs_addr_i         (slot_q.rs1_addr),
    .reg_value_i       (slot_q.rs1_val),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_result_i    (bus.exmem_result),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_result_i    (bus.memwb_result),
    .value_o           (fwd_rs1)
  );

  alu_operand_stage_forward_mux u_fwd_rs2 (
    .rs_addr_i         (slot_q.rs2_addr),
    .reg_value_i       (slot_q.rs2_val),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_result_i    (bus.exmem_result),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_result_i    (bus.memwb_result),
    .value_o           (fwd_rs2)
  );

  // Stall reloads the operand registers with their forwarded value so a
  // result stays visible after its producer leaves EX/MEM or MEM/WB.
  always_comb begin
    slot_d = slot_q;
    if (bus.flush) begin
      slot_d.valid     = 1'b0;
      slot_d.reg_write = 1'b0;
    end else if (bus.stall) begin
      slot_d.rs1_val = fwd_rs1;
      slot_d.rs2_val = fwd_rs2;
    end else begin
      slot_d.valid     = bus.id_valid;
      slot_d.reg_write = bus.id_reg_write & bus.id_valid;
      slot_d.pc        = bus.id_pc;
      slot_d.rs1_val   = bus.id_rs1_data;
      slot_d.rs2_val   = bus.id_rs2_data;
      slot_d.imm       = bus.id_imm;
      slot_d.rs1_addr  = bus.id_rs1_addr;
      slot_d.rs2_addr  = bus.id_rs2_addr;
      slot_d.rd_addr   = bus.id_rd_addr;
      slot_d.alu_op    = bus.id_alu_op;
      slot_d.a_sel     = bus.id_a_sel;
      slot_d.b_sel     = bus.id_b_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q        <= '0;
      slot_q.alu_op <= ALU_ADD;
    end else begin
      slot_q <= slot_d;
    end
  end

  logic [XLEN-1:0] in_a, in_b;

  always_comb begin
    in_a = '0;
    case (slot_q.a_sel)
      A_SEL_RS1:  in_a = fwd_rs1;
      A_SEL_PC:   in_a = slot_q.pc;
      A_SEL_ZERO: in_a = '0;
      default:    in_a = '0;
    endcase
  end

  always_comb begin
    in_b = '0;
    case (slot_q.b_sel)
      B_SEL_RS2:  in_b = fwd_rs2;
      B_SEL_IMM:  in_b = slot_q.imm;
      B_SEL_FOUR: in_b = XLEN'(4);
      default:    in_b = '0;
    endcase
  end

  assign bus.in_a         = in_a;
  assign bus.in_b         = in_b;
  assign bus.ex_valid     = slot_q.valid;
  assign bus.op_code      = slot_q.alu_op;
  assign bus.ex_rs2_value = fwd_rs2;
  assign bus.ex_pc        = slot_q.pc;
  assign bus.ex_rd_addr   = slot_q.rd_addr;
  assign bus.ex_reg_write = slot_q.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: reset, capture, forwarding
// priority, x0 guard, stall refresh, flush and operand select cases.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic valid, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [3:0] op, input logic [1:0] asel,
                        input logic [1:0] bsel, input logic we);
    bus.id_valid     = valid;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = rs1;
    bus.id_rs1_data  = d1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_rd_addr   = rd;
    bus.id_alu_op    = op;
    bus.id_a_sel     = asel;
    bus.id_b_sel     = bsel;
    bus.id_reg_write = we;
  endtask

  task automatic clr_fwd();
    bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b0; bus.exmem_result = '0;
    bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b0; bus.memwb_result = '0;
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clr_fwd();
    set_id(1'b1, 32'h44, 5'd3, 32'hAA, 5'd4, 32'hBB, 32'h12, 5'd2, ALU_XOR,
           A_SEL_RS1, B_SEL_RS2, 1'b1);

    // reset held two cycles while decode offers a live instruction
    step();
    step();
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_we",    32'(bus.ex_reg_write), 32'd0);
    chk("rst_op",    32'(bus.op_code), 32'(ALU_ADD));
    chk("rst_in_a",  bus.in_a, 32'd0);
    chk("rst_in_b",  bus.in_b, 32'd0);
    reset = 1'b0;

    // plain capture
    set_id(1'b1, 32'h40, 5'd5, 32'd10, 5'd6, 32'd3, 32'h0, 5'd9, ALU_SUB,
           A_SEL_RS1, B_SEL_RS2, 1'b1);
    step();
    chk("cap_in_a",  bus.in_a, 32'd10);
    chk("cap_in_b",  bus.in_b, 32'd3);
    chk("cap_op",    32'(bus.op_code), 32'(ALU_SUB));
    chk("cap_valid", 32'(bus.ex_valid), 32'd1);
    chk("cap_we",    32'(bus.ex_reg_write), 32'd1);
    chk("cap_rd",    32'(bus.ex_rd_addr), 32'd9);
    chk("cap_pc",    bus.ex_pc, 32'h40);
    chk("cap_rs2v",  bus.ex_rs2_value, 32'd3);

    // forward priority, combinational within one cycle
    bus.exmem_rd = 5'd5; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'h11;
    bus.memwb_rd = 5'd5; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h22;
    #1;
    chk("fwd_exmem", bus.in_a, 32'h11);
    chk("fwd_b_untouched", bus.in_b, 32'd3);
    bus.exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", bus.in_a, 32'h22);
    bus.memwb_rd = 5'd6;
    #1;
    chk("fwd_rs2_memwb", bus.ex_rs2_value, 32'h22);
    chk("fwd_a_back", bus.in_a, 32'd10);
    clr_fwd();

    // x0 guard: captured data is nonzero but x0 still reads zero
    set_id(1'b1, 32'h50, 5'd0, 32'h77, 5'd0, 32'h66, 32'h0, 5'd1, ALU_ADD,
           A_SEL_RS1, B_SEL_RS2, 1'b1);
    step();
    bus.exmem_rd = 5'd0; bus.exmem_reg_write = 1'b1; bus.exmem_result = 32'hFF;
    bus.memwb_rd = 5'd0; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'hEE;
    #1;
    chk("x0_in_a", bus.in_a, 32'd0);
    chk("x0_in_b", bus.in_b, 32'd0);
    clr_fwd();

    // stall refresh
    set_id(1'b1, 32'h80, 5'd1, 32'h5, 5'd7, 32'h9, 32'h0, 5'd3, ALU_OR,
           A_SEL_RS1, B_SEL_RS2, 1'b1);
    step();
    chk("pre_stall_in_b", bus.in_b, 32'h9);
    set_id(1'b1, 32'h200, 5'd2, 32'h33, 5'd8, 32'h44, 32'h0, 5'd4, ALU_AND,
           A_SEL_RS1, B_SEL_RS2, 1'b0);
    bus.stall = 1'b1;
    bus.memwb_rd = 5'd7; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h55;
    #1;
    chk("stall0_in_b", bus.in_b, 32'h55);
    for (int i = 1; i <= 3; i++) begin
      step();
      clr_fwd();
      #1;
      chk($sformatf("stall%0d_in_b", i), bus.in_b, 32'h55);
      chk($sformatf("stall%0d_pc", i), bus.ex_pc, 32'h80);
      chk($sformatf("stall%0d_op", i), 32'(bus.op_code), 32'(ALU_OR));
      chk($sformatf("stall%0d_in_a", i), bus.in_a, 32'h5);
    end
    bus.stall = 1'b0;
    #1;
    chk("post_stall_in_b", bus.in_b, 32'h55);
    chk("post_stall_rd", 32'(bus.ex_rd_addr), 32'd3);
    step();
    chk("resume_pc", bus.ex_pc, 32'h200);
    chk("resume_in_a", bus.in_a, 32'h33);
    chk("resume_we_off", 32'(bus.ex_reg_write), 32'd0);

    // flush together with stall
    set_id(1'b1, 32'h300, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd5, ALU_ADD,
           A_SEL_RS1, B_SEL_RS2, 1'b1);
    step();
    chk("pre_flush_valid", 32'(bus.ex_valid), 32'd1);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    chk("flush_stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_stall_we", 32'(bus.ex_reg_write), 32'd0);

    // flush alone, then capture pc/four selects
    bus.stall = 1'b0;
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;
    set_id(1'b1, 32'h100, 5'd1, 32'h7, 5'd2, 32'h8, 32'h0, 5'd6, ALU_ADD,
           A_SEL_PC, B_SEL_FOUR, 1'b1);
    step();
    chk("pc4_in_a", bus.in_a, 32'h100);
    chk("pc4_in_b", bus.in_b, 32'd4);
    chk("pc4_valid", 32'(bus.ex_valid), 32'd1);
    chk("pc4_rs2v", bus.ex_rs2_value, 32'h8);

    // zero / imm selects, and an invalid slot suppresses reg_write
    set_id(1'b0, 32'h104, 5'd1, 32'h7, 5'd2, 32'h8, 32'hABC, 5'd6, ALU_SLT,
           A_SEL_ZERO, B_SEL_IMM, 1'b1);
    step();
    chk("zimm_in_a", bus.in_a, 32'd0);
    chk("zimm_in_b", bus.in_b, 32'hABC);
    chk("inv_valid", 32'(bus.ex_valid), 32'd0);
    chk("inv_we", 32'(bus.ex_reg_write), 32'd0);

    // select value 3 yields zero on both operands
    set_id(1'b1, 32'h108, 5'd1, 32'h7, 5'd2, 32'h8, 32'hABC, 5'd6, ALU_SRA,
           2'd3, 2'd3, 1'b1);
    step();
    chk("sel3_in_a", bus.in_a, 32'd0);
    chk("sel3_in_b", bus.in_b, 32'd0);
    chk("sel3_rs2v", bus.ex_rs2_value, 32'h8);

    // reset during stall clears the slot
    bus.stall = 1'b1;
    bus.memwb_rd = 5'd1; bus.memwb_reg_write = 1'b1; bus.memwb_result = 32'h99;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr_fwd();
    #1;
    chk("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_stall_op", 32'(bus.op_code), 32'(ALU_ADD));
    chk("rst_stall_pc", bus.ex_pc, 32'd0);
    chk("rst_stall_rs2v", bus.ex_rs2_value, 32'd0);
    bus.stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It captures a decoded instruction on each clock and selects the two ALU operands from register data, PC or immediate. It resolves RAW hazards by forwarding results from EX/MEM and MEM/WB. It also supports pipeline stall and flush, and delivers `in_a`, `in_b` and `op_code` to the ALU plus writeback control to later stages.

## Interface
- `XLEN`, 32, datapath width
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold current EX contents
- `flush`  in  1  replace captured instruction with bubble
- `id_valid`  in  1  decode slot holds an instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN  decoded fields
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  5  register indices
- `id_alu_op`  in  4  ALU op code (ADD…AND encoding from `alu_func.vh`)
- `id_a_sel`  in  2  operand A: 0=rs1, 1=pc, 2=zero
- `id_b_sel`  in  2  operand B: 0=rs2, 1=imm, 2=constant 4
- `id_reg_write`  in  1  instruction writes rd
- `exmem_rd`, `memwb_rd`  in  5  destination of older instructions
- `exmem_reg_write`, `memwb_reg_write`  in  1  older instruction writes rd
- `exmem_result`, `memwb_result`  in  XLEN  older results
- `ex_valid`  out  1  EX slot holds a live instruction
- `in_a`, `in_b`  out  XLEN  ALU operands
- `op_code`  out  4  ALU op code
- `ex_rs2_value`  out  XLEN  forwarded rs2 (store data)
- `ex_pc`  out  XLEN  PC of EX instruction
- `ex_rd_addr`  out  5;  `ex_reg_write`  out  1

## Operation
- Per-cycle register update, priority: reset > flush > stall > capture.
  - **reset**: all state registers 0; `op_code` = ADD; `ex_valid` = `ex_reg_write` = 0.
  - **flush**: `ex_valid` = 0, `ex_reg_write` = 0; other fields don't-care (held).
  - **stall**: hold all fields except rs1/rs2 value registers, which reload with their current forwarded value (operand refresh).
  - **capture**: load all `id_*` fields. `ex_valid` = `id_valid`, `ex_reg_write` = `id_reg_write & id_valid`.
- Operand refresh keeps a forwarded value alive after its producer retires during a multi-cycle stall.
- Forwarding, per source register `rs` (combinational from registered fields):
  - EX/MEM hit when `exmem_reg_write`, `exmem_rd == rs` and `rs != 0` → `exmem_result`.
  - Else MEM/WB hit under the same conditions → `memwb_result`.
  - Else the registered value.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded and reads 0.
- Operand muxing:
  - `in_a` = fwd_rs1 / `ex_pc` / 0 per a_sel.
  - `in_b` = fwd_rs2 / imm / 4 per b_sel.
  - sel = 3 yields 0.
- `ex_rs2_value` = fwd_rs2, regardless of b_sel.
- Bubble output (`ex_valid` = 0) still drives operands. Consumers must qualify with `ex_valid`.

## Timing
- Capture latency 1 cycle: `id_*` sampled at edge N appears on outputs after edge N.
- Forward paths are combinational, 0 cycles, from `exmem_*`/`memwb_*` to `in_a`/`in_b`/`ex_rs2_value`.
- `stall` and `flush` are sampled at the same edge.
  - flush + stall together → flush.
  - reset + anything → reset.
- Reset asserted mid-stall clears the slot; refreshed operands are discarded.

## Structure
- `alu_func.vh`: ALU op codes (existing).
- New `execute_defs.vh` holds:
  - A_SEL_RS1/PC/ZERO and B_SEL_RS2/IMM/FOUR constants.
  - FWD_NONE/EXMEM/MEMWB forward-select codes.
- One sub-module, `forward_mux`. It takes a reg index, registered value and both forward sources, returns the forwarded value, and is instantiated twice (rs1, rs2).

## Test plan
- **Reset behaviour**: reset=1 for 2 cycles with `id_valid`=1 → `ex_valid`=0, `ex_reg_write`=0, `op_code`=ADD, `in_a`=`in_b`=0.
- **Plain capture**: capture rs1=5 (data 10), rs2=6 (data 3), op=SUB, a_sel=0, b_sel=0, no hazards → next cycle `in_a`=10, `in_b`=3, `op_code`=SUB, `ex_valid`=1.
- **Forward priority**: EX rs1=5, `exmem_rd`=5 result 0x11, `memwb_rd`=5 result 0x22 → `in_a`=0x11. Drop `exmem_reg_write` → `in_a`=0x22.
- **x0 guard**: rs1=0, `exmem_rd`=0, `exmem_reg_write`=1, result 0xFF → `in_a`=0.
- **Stall refresh**:
  - Stall 3 cycles; rs2=7 hits MEM/WB result 0x55 in the first stall cycle only.
  - All fields held, `ex_pc` unchanged, and `in_b` stays 0x55 through the stall and the first post-stall cycle.
- **Flush**:
  - Flush with stall together → `ex_valid`=0, `ex_reg_write`=0 next cycle.
  - Flush alone with a_sel=1, b_sel=2, pc=0x100 on the next capture → `in_a`=0x100, `in_b`=4.
